// File: rtl/skid_buffer.sv
// Two-entry elastic stage (main + skid register) that breaks the ready path between producer and consumer.
// Optional synchronous flush port enabled by defining SKID_FLUSH_EN.
module skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
`ifdef SKID_FLUSH_EN
  input  logic                  i_flush,
`endif
  output logic [1:0]            dbg_state
);

  // Encoding equals the number of buffered words: 0 empty, 1 busy, 2 full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  up_xfer;
  logic                  dn_xfer;

  // Handshake: a word moves on a rising edge only when valid and ready are both 1
  // at that edge; o_valid/o_ready are flops so neither depends on i_valid/i_ready.
  assign up_xfer   = i_valid & o_ready;
  assign dn_xfer   = o_valid & i_ready;
  assign o_data    = main_q;
  assign dbg_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end
`ifdef SKID_FLUSH_EN
    else if (i_flush) begin
      // Data registers keep their contents; only occupancy is dropped.
      state   <= EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end
`endif
    else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            main_q  <= i_data;
            state   <= BUSY;
            o_valid <= 1'b1;
            o_ready <= 1'b1;
          end
        end
        BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_q <= i_data;
          end else if (up_xfer) begin
            skid_q  <= i_data;
            state   <= FULL;
            o_valid <= 1'b1;
            o_ready <= 1'b0;
          end else if (dn_xfer) begin
            state   <= EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        FULL: begin
          // Upstream is already blocked here, so only the drain matters.
          if (dn_xfer) begin
            main_q  <= skid_q;
            state   <= BUSY;
            o_valid <= 1'b1;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed scenarios, then randomized traffic against a queue model.
module tb_skid_buffer;

  localparam int W = 32;

  logic         clk;
  logic         i_rst;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic         i_flush;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  skid_buffer #(.DATA_WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
`ifdef SKID_FLUSH_EN
    .i_flush   (i_flush),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog expired");
  end

  // One clock edge; the queue model applies the transfers the handshake rules allow.
  task automatic tick();
    bit           up;
    bit           dn;
    logic [W-1:0] d;
    up = i_valid && (exp_q.size() < 2);
    dn = (exp_q.size() > 0) && i_ready;
    d  = i_data;
    @(posedge clk);
    if (i_flush) begin
      exp_q.delete();
    end else begin
      if (dn) void'(exp_q.pop_front());
      if (up) exp_q.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic       exp_v;
    logic       exp_r;
    logic [1:0] exp_s;
    exp_v = (exp_q.size() > 0);
    exp_r = (exp_q.size() < 2);
    exp_s = 2'(exp_q.size());
    n_checks++;
    assert (o_valid === exp_v) else begin
      n_fail++;
      $error("FAIL %s o_valid got %0b need %0b", tag, o_valid, exp_v);
    end
    n_checks++;
    assert (o_ready === exp_r) else begin
      n_fail++;
      $error("FAIL %s o_ready got %0b need %0b", tag, o_ready, exp_r);
    end
    n_checks++;
    assert (dbg_state === exp_s) else begin
      n_fail++;
      $error("FAIL %s state got %0d need %0d", tag, dbg_state, exp_s);
    end
    if (exp_v) begin
      n_checks++;
      assert (o_data === exp_q[0]) else begin
        n_fail++;
        $error("FAIL %s o_data got %h need %h", tag, o_data, exp_q[0]);
      end
    end
  endtask

  task automatic check_data(input string tag, input logic [W-1:0] exp);
    n_checks++;
    assert (o_data === exp) else begin
      n_fail++;
      $error("FAIL %s o_data got %h need %h", tag, o_data, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0b need %0b", tag, got, exp);
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    #1;
    check_bit("reset_valid", o_valid, 1'b0);
    check_bit("reset_ready", o_ready, 1'b1);
    check_data("reset_data", '0);
    #12;
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    // First edge after reset release accepts a word; it shows up one cycle later.
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_data  = 32'h0000_00F0;
    tick();
    check_data("first_after_reset", 32'h0000_00F0);
    check_model("first_after_reset");

    // Streaming 1..8 back-to-back
    for (int k = 1; k <= 8; k++) begin
      i_data = W'(k);
      tick();
      check_data("stream", W'(k));
      check_bit("stream_ready", o_ready, 1'b1);
      check_model("stream");
    end
    i_valid = 1'b0;
    tick();
    check_bit("stream_drained", o_valid, 1'b0);
    check_model("stream_drained");

    // Backpressure: fill to FULL, hold, then drain in order
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hA;
    tick();
    check_data("bp_a_busy", 32'hA);
    check_model("bp_a_busy");
    i_data = 32'hB;
    tick();
    check_bit("bp_full_ready", o_ready, 1'b0);
    check_data("bp_full_a", 32'hA);
    check_model("bp_full");
    i_data = 32'hEE;
    tick();
    check_data("bp_hold_a", 32'hA);
    check_model("bp_hold_blocked");
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check_data("bp_out_b", 32'hB);
    check_model("bp_out_b");
    tick();
    check_bit("bp_empty", o_valid, 1'b0);
    check_model("bp_empty");

    // Simultaneous in/out while BUSY
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hC;
    tick();
    check_data("sim_c", 32'hC);
    i_data  = 32'hD;
    i_ready = 1'b1;
    tick();
    check_data("sim_d", 32'hD);
    check_model("sim_busy");

`ifdef SKID_FLUSH_EN
    // Flush from FULL drops the incoming word too
    i_ready = 1'b0;
    i_data  = 32'h11;
    tick();
    check_model("flush_fill");
    i_data  = 32'h22;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check_bit("flush_valid", o_valid, 1'b0);
    check_bit("flush_ready", o_ready, 1'b1);
    check_model("flush");
`endif

    // Reset asserted mid-cycle with two words buffered
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h55;
    tick();
    i_data  = 32'h66;
    tick();
    check_model("pre_reset_full");
    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    exp_q.delete();
    check_bit("midreset_valid", o_valid, 1'b0);
    check_bit("midreset_ready", o_ready, 1'b1);
    check_data("midreset_data", '0);
    @(posedge clk);
    #3;
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    check_model("post_reset");

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 3) != 0);
      i_data  = $urandom;
      tick();
      check_model("random");
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_model("final_drain");
    end
    check_bit("final_empty", o_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
